// File: rtl/adam_aes_key_expansion_reverse.sv
// Reverse AES-128 key schedule: walks round keys 10 down to 0 over a valid/ready stream.
// Optional macro ADAM_AES_KEYEXP_REV_INVMC_EN applies InvMixColumns to keys 1..9 on the output.

module adam_aes_sbox_byte (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign s_o = sbox(a_i);

endmodule

module adam_aes_key_expansion_reverse #(
  parameter int NR = 10  // only AES-128 (10 rounds) is supported
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] last_key,
  input  logic         init,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  // Handshake: a key transfers on any rising clk edge where rk_valid && rk_ready;
  // rk_valid never drops and rk_data/rk_idx never change until that transfer happens.

  localparam logic [3:0] LastRound = 4'(NR);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_STEP, S_DONE} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   ctr_q, ctr_d;

  logic [31:0]  wa, wb, wc, wd;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot;
  logic [31:0]  sub;
  logic [127:0] key_out;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  assign {wa, wb, wc, wd} = key_q;
  assign p3  = wd ^ wc;
  assign p2  = wc ^ wb;
  assign p1  = wb ^ wa;
  assign rot = {p3[23:0], p3[31:24]};

  adam_aes_sbox_byte u_sbox0 (.a_i(rot[31:24]), .s_o(sub[31:24]));
  adam_aes_sbox_byte u_sbox1 (.a_i(rot[23:16]), .s_o(sub[23:16]));
  adam_aes_sbox_byte u_sbox2 (.a_i(rot[15:8]),  .s_o(sub[15:8]));
  adam_aes_sbox_byte u_sbox3 (.a_i(rot[7:0]),   .s_o(sub[7:0]));

  assign p0 = wa ^ sub ^ {rcon(ctr_q), 24'h0};

`ifdef ADAM_AES_KEYEXP_REV_INVMC_EN
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // 9,11,13,14 multiples built from x2/x4/x8.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    key_out = key_q;
    if (ctr_q != 4'd0 && ctr_q != LastRound) begin
      key_out = {inv_mix_col(wa), inv_mix_col(wb), inv_mix_col(wc), inv_mix_col(wd)};
    end
  end
`else
  assign key_out = key_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    key_d    = key_q;
    ctr_d    = ctr_q;
    rk_valid = 1'b0;
    rk_data  = '0;
    rk_idx   = '0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (init) begin
          key_d   = last_key;
          ctr_d   = LastRound;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        rk_valid = 1'b1;
        rk_data  = key_out;
        rk_idx   = ctr_q;
        busy     = 1'b1;
        if (rk_ready) state_d = (ctr_q == 4'd0) ? S_DONE : S_STEP;
      end
      S_STEP: begin
        busy    = 1'b1;
        key_d   = {p0, p1, p2, p3};
        ctr_d   = ctr_q - 4'd1;
        state_d = S_EMIT;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adam_aes_key_expansion_reverse.sv
// Bench for adam_aes_key_expansion_reverse: forward-schedule reference, directed and random runs.
// Honours ADAM_AES_KEYEXP_REV_INVMC_EN in its expected values.

module tb_adam_aes_key_expansion_reverse;

  logic         clk;
  logic         reset_n;
  logic [127:0] last_key;
  logic         init;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  int n_checks;
  int n_fail;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk_ref [11];
  logic [127:0] got    [11];
  logic [131:0] exp_q  [$];

  adam_aes_key_expansion_reverse dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .last_key (last_key),
    .init     (init),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_data  (rk_data),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: FIPS-197 forward key expansion
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p;
    int x;
    p = 0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if (x > 255) x = (x ^ 'h11b);
    end
    return 8'(p);
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk_ref[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [7:0] m [4][4];
    logic [7:0] a [4];
    logic [7:0] o;
    logic [127:0] r;
    m = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09}, '{8'h09, 8'h0e, 8'h0b, 8'h0d},
          '{8'h0d, 8'h09, 8'h0e, 8'h0b}, '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) a[i] = s[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gmul(m[i][j], a[j]);
        r[127-32*c-8*i -: 8] = o;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] model_out(input int r);
`ifdef ADAM_AES_KEYEXP_REV_INVMC_EN
    if (r >= 1 && r <= 9) return inv_mix(rk_ref[r]);
`endif
    return rk_ref[r];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Driver tasks
  task automatic apply_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    init     = 1'b0;
    rk_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One full run from IDLE; idx 9 is held off for stall_len cycles, init pulses at glitch_cyc.
  task automatic run_seq(input logic [127:0] key0, input int stall_len, input int glitch_cyc,
                         input bit hold_init);
    int          cyc;
    int          done_cyc;
    int          stalled;
    int          h;
    int          start;
    bit          vexp;
    bit          rdy;
    bit          finished;
    logic [131:0] head;
    expand(key0);
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), model_out(r)});
    @(negedge clk);
    last_key = rk_ref[10];
    init     = 1'b1;
    rk_ready = 1'($urandom_range(0, 1));
    cyc      = 0;
    done_cyc = -10;
    stalled  = 0;
    finished = 1'b0;
    while (!finished && cyc < 80) begin
      @(negedge clk);
      cyc++;
      init = hold_init || (cyc == glitch_cyc);
      if (cyc == glitch_cyc) last_key = rand128();
      if (exp_q.size() != 0) begin
        head  = exp_q[0];
        h     = int'(head[131:128]);
        start = 1 + 2 * (10 - h) + ((h < 9) ? stall_len : 0);
        vexp  = (cyc >= start);
        rdy   = 1'b1;
        if (vexp && h == 9 && stalled < stall_len) begin
          rdy = 1'b0;
          stalled++;
        end
        if (!vexp) rdy = 1'($urandom_range(0, 1));
        rk_ready = rdy;
        chk("rk_valid", 132'(rk_valid), 132'(vexp));
        chk("busy_run", 132'(busy), 132'(1));
        chk("done_early", 132'(done), 132'(0));
        if (vexp) begin
          chk("rk_key", {rk_idx, rk_data}, head);
          got[h] = rk_data;
          if (rdy) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) done_cyc = cyc + 1;
          end
        end
      end else begin
        rk_ready = 1'($urandom_range(0, 1));
        if (cyc == done_cyc) begin
          chk("done_pulse", 132'(done), 132'(1));
          chk("busy_done", 132'(busy), 132'(0));
          chk("valid_done", 132'(rk_valid), 132'(0));
          chk("done_cycle", 132'(cyc), 132'(22 + stall_len));
        end else if (cyc == done_cyc + 1) begin
          chk("done_once", 132'(done), 132'(0));
          chk("busy_idle", 132'(busy), 132'(0));
          chk("valid_idle", 132'(rk_valid), 132'(0));
          if (!hold_init) finished = 1'b1;
        end else if (cyc == done_cyc + 2) begin
          chk("restart_valid", 132'(rk_valid), 132'(1));
          chk("restart_idx", 132'(rk_idx), 132'(10));
          finished = 1'b1;
        end
      end
    end
    if (!finished) chk("timeout", 132'(0), 132'(1));
    init = 1'b0;
    if (hold_init) apply_reset();
  endtask

  initial begin
    logic [127:0] fips_k;
    bit           saw_done;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    init     = 1'b0;
    rk_ready = 1'b0;
    last_key = '0;
    fips_k   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    build_sbox();

    // Reset state
    @(negedge clk);
    chk("rst_valid", 132'(rk_valid), 132'(0));
    chk("rst_data", 132'(rk_data), 132'(0));
    chk("rst_idx", 132'(rk_idx), 132'(0));
    chk("rst_busy", 132'(busy), 132'(0));
    chk("rst_done", 132'(done), 132'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // FIPS-197 A.1 vector, no stall
    run_seq(fips_k, 0, -1, 1'b0);
    chk("fips_idx10", 132'(got[10]), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
`ifdef ADAM_AES_KEYEXP_REV_INVMC_EN
    chk("fips_idx9", 132'(got[9]), 132'(inv_mix(128'hac7766f319fadc2128d12941575c006e)));
`else
    chk("fips_idx9", 132'(got[9]), 132'(128'hac7766f319fadc2128d12941575c006e));
`endif
    chk("fips_idx0", 132'(got[0]), 132'(fips_k));

    // Backpressure on idx 9
    run_seq(fips_k, 5, -1, 1'b0);

    // init during a run is ignored
    run_seq(fips_k, 0, 5, 1'b0);

    // Reset mid-operation
    expand(fips_k);
    @(negedge clk);
    last_key = rk_ref[10];
    init     = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      init     = 1'b0;
      rk_ready = 1'b1;
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", 132'(rk_valid), 132'(0));
    chk("abort_busy", 132'(busy), 132'(0));
    chk("abort_data", 132'(rk_data), 132'(0));
    chk("abort_done", 132'(done), 132'(0));
    reset_n  = 1'b1;
    saw_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 132'(saw_done), 132'(0));
    run_seq(fips_k, 0, -1, 1'b0);

    // init held high through DONE -> IDLE restarts
    run_seq(fips_k, 0, -1, 1'b1);

    // Random keys against the forward schedule
    for (int n = 0; n < 100; n++) begin
      run_seq(rand128(), int'($urandom_range(0, 3)), -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adam_aes_key_expansion_reverse.md
Name: adam_aes_key_expansion_reverse

Overview:
Reverse AES-128 key schedule for the ADAM AES decryption path. It takes the final round key (round 10) and walks the schedule backwards, streaming round keys 10, 9, … 0 to the inverse-cipher datapath over a valid/ready handshake. Four shared S-box byte instances (adam_aes_sbox_byte) are used, one step per round. Only round 10's key is stored.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) is supported.

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
last_key  input  128  round-10 key {w40,w41,w42,w43}, w40 at [127:96]
init  input  1  start pulse; sampled only in IDLE
rk_valid  output  1  rk_data/rk_idx valid
rk_ready  input  1  consumer accepts the current key
rk_data  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}
rk_idx  output  4  round number r of rk_data (10 down to 0)
busy  output  1  high from the cycle after init until done
done  output  1  one-cycle pulse after round key 0 is accepted

Behaviour:
- Clock and reset: clk; reset_n asynchronous, active-low. Reset drives all registers to 0 and the state to IDLE: rk_valid=0, rk_data=0, rk_idx=0, busy=0, done=0.
- State machine states: IDLE, EMIT, STEP, DONE.
- IDLE:
  - init=1 loads key_reg<=last_key and ctr<=10, then moves to EMIT.
  - init in any other state is ignored.
- EMIT:
  - rk_valid=1, rk_data=key_reg, rk_idx=ctr.
  - While rk_valid=1 and rk_ready=0, rk_data and rk_idx stay stable.
  - Handshake: on rk_valid&&rk_ready, if ctr==0 go to DONE, else go to STEP.
- STEP (1 cycle, rk_valid=0): with current words a,b,c,d (a=[127:96]):
  - p3=d^c, p2=c^b, p1=b^a.
  - t=SubWord(RotWord(p3)); RotWord(x)={x[23:0],x[31:24]}; S-box inputs are bytes of RotWord(p3), MSB byte on sbox 0.
  - p0=a^t^{rcon(ctr),24'h0}.
  - rcon: 1..8 = 01,02,04,08,10,20,40,80; 9=1B; 10=36.
  - key_reg<={p0,p1,p2,p3}, ctr<=ctr-1, go to EMIT.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops to 0 in the same cycle done goes high.
- busy=1 in EMIT and STEP.
- Latency:
  - init at cycle 0 gives rk_valid with idx 10 at cycle 1.
  - With rk_ready tied high, idx k is valid at cycle 1+2*(10-k); idx 0 is at cycle 21, done at cycle 22.
  - Any rk_ready stall adds cycles one for one.
- rk_ready outside EMIT has no effect.
- ctr never wraps: no STEP is taken from ctr==0.
- Reset mid-operation aborts immediately with no done pulse. Next init starts from round 10.
- init held high through DONE→IDLE restarts on the first IDLE cycle with init=1.

Optional Feature:
ADAM_AES_KEYEXP_REV_INVMC_EN
- Defined: for rk_idx 1..9, rk_data = InvMixColumns(key_reg), applied per 32-bit column, for the equivalent inverse cipher. idx 10 and idx 0 are output unmodified.
  - The transform is combinational on the output path. key_reg (the schedule state) is never modified.
- Not defined: rk_data = key_reg for all rounds.

Test Plan:
- FIPS-197 A.1: last_key=d014f9a8c9ee2589e13f0cc8b6630ca6, init pulse, rk_ready=1 -> rk_idx 10 at cycle 1 with that value; idx 9 = ac7766f319fadc2128d12941575c006e at cycle 3; idx 0 = 2b7e151628aed2a6abf7158809cf4f3c at cycle 21; done high at cycle 22 only.
- Backpressure: as above with rk_ready low for 5 cycles on idx 9 -> rk_data/rk_idx constant throughout; sequence unchanged; done at cycle 27.
- init asserted at cycle 5 during run -> ignored; sequence and done timing identical to the first test.
- reset_n low at cycle 8 -> next cycle rk_valid=0, busy=0, rk_data=0, no done; new init restarts at idx 10.
- Forward cross-check: random key K, forward-expanded round 10 key fed in -> idx 0 output equals K, all 11 keys match the forward schedule (100 random keys).
- With ADAM_AES_KEYEXP_REV_INVMC_EN: FIPS-197 vector -> idx 10 and idx 0 unchanged; idx 9 equals InvMixColumns(ac7766f3…006e) per reference model.
